// File: rtl/coalescing_write_buffer.sv
// Line-coalescing write buffer: merges L1 write-through words into line entries
// and drains them to memory in FIFO order. Define WB_FORWARD_EN to forward buffered words to read probes.
module coalescing_write_buffer #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned WORDS        = 4,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DRAIN_THRESH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    rd_check,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    rd_hit,
  output logic [DATA_W-1:0]       rd_data,
  input  logic                    flush,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_W-1:0]       mem_req_addr,
  output logic [WORDS*DATA_W-1:0] mem_req_data,
  output logic [WORDS-1:0]        mem_req_mask,
  input  logic                    mem_done,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WIDX_W = $clog2(WORDS);
  localparam int unsigned TAG_W  = ADDR_W - WIDX_W;
  localparam int unsigned LINE_W = WORDS * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t state;

  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [LINE_W-1:0] line_q [DEPTH];
  logic [WORDS-1:0]  mask_q [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  function automatic logic [DATA_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                 input logic [WIDX_W-1:0] idx);
    get_word = '0;
    for (int w = 0; w < int'(WORDS); w++)
      if (WIDX_W'(w) == idx) get_word = line[w*DATA_W +: DATA_W];
  endfunction

  function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                 input logic [WIDX_W-1:0] idx,
                                                 input logic [DATA_W-1:0] data);
    put_word = line;
    for (int w = 0; w < int'(WORDS); w++)
      if (WIDX_W'(w) == idx) put_word[w*DATA_W +: DATA_W] = data;
  endfunction

  logic [TAG_W-1:0]  wr_tag;
  logic [TAG_W-1:0]  rd_tag;
  logic [WIDX_W-1:0] wr_word;
  logic [WIDX_W-1:0] rd_word;
  logic              in_flight;

  assign wr_tag    = wr_addr[ADDR_W-1:WIDX_W];
  assign wr_word   = wr_addr[WIDX_W-1:0];
  assign rd_tag    = rd_addr[ADDR_W-1:WIDX_W];
  assign rd_word   = rd_addr[WIDX_W-1:0];
  assign in_flight = (state != S_IDLE);

  // Merge target: the single occupied entry with this tag that is not being drained.
  logic             merge_hit;
  logic [PTR_W-1:0] merge_idx;
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (mask_q[i] != '0 && tag_q[i] == wr_tag &&
          !(in_flight && PTR_W'(i) == head)) begin
        merge_hit = 1'b1;
        merge_idx = PTR_W'(i);
      end
    end
  end

  logic             wr_fire;
  logic             alloc;
  logic             retire;
  logic [PTR_W-1:0] wr_idx;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign wr_ready = merge_hit || !full;
  assign wr_fire  = wr_valid && wr_ready;
  assign alloc    = wr_fire && !merge_hit;
  assign retire   = (state == S_WAIT) && mem_done;
  assign wr_idx   = merge_hit ? merge_idx : tail;

  // New contents of the written entry; a fresh allocation starts from a zeroed line.
  logic [LINE_W-1:0] wr_line_n;
  logic [WORDS-1:0]  wr_mask_n;
  always_comb begin
    wr_line_n = put_word(alloc ? LINE_W'(0) : line_q[wr_idx], wr_word, wr_data);
    wr_mask_n = (alloc ? WORDS'(0) : mask_q[wr_idx]) | (WORDS'(1) << wr_word);
  end

  // Head as it will look after this cycle's write, so a same-cycle merge is captured.
  logic              head_wr;
  logic [TAG_W-1:0]  head_tag_n;
  logic [LINE_W-1:0] head_line_n;
  logic [WORDS-1:0]  head_mask_n;
  always_comb begin
    head_wr     = wr_fire && (wr_idx == head);
    head_tag_n  = head_wr ? wr_tag    : tag_q[head];
    head_line_n = head_wr ? wr_line_n : line_q[head];
    head_mask_n = head_wr ? wr_mask_n : mask_q[head];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mask_q[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_fire) mask_q[wr_idx] <= wr_mask_n;
      if (retire) begin
        mask_q[head] <= '0;
        head         <= head + PTR_W'(1);
      end
      if (alloc) tail <= tail + PTR_W'(1);
      case ({alloc, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage; occupancy is governed solely by the masks.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      tag_q[wr_idx]  <= wr_tag;
      line_q[wr_idx] <= wr_line_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      mem_req_mask  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (count >= CNT_W'(DRAIN_THRESH) || (flush && !empty)) begin
            state         <= S_REQ;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= {head_tag_n, WIDX_W'(0)};
            mem_req_data  <= head_line_n;
            mem_req_mask  <= head_mask_n;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state         <= S_WAIT;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
            mem_req_mask  <= '0;
          end
        end
        S_WAIT: begin
          if (mem_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Probe walks oldest to youngest so the youngest qualifying entry wins.
  logic [PTR_W-1:0] probe_idx;
  always_comb begin
    rd_hit    = 1'b0;
    rd_data   = '0;
    probe_idx = head;
    for (int k = 0; k < int'(DEPTH); k++) begin
      probe_idx = head + PTR_W'(k);
      if (rd_check && mask_q[probe_idx] != '0 && tag_q[probe_idx] == rd_tag) begin
`ifdef WB_FORWARD_EN
        if (mask_q[probe_idx][rd_word]) begin
          rd_hit  = 1'b1;
          rd_data = get_word(line_q[probe_idx], rd_word);
        end
`else
        rd_hit = 1'b1;
`endif
      end
    end
  end

`ifndef WB_FORWARD_EN
  logic unused_rd_word;
  assign unused_rd_word = ^rd_word;
`endif

endmodule

// File: doc/coalescing_write_buffer.md
Name: coalescing_write_buffer

Overview:
Parametrised line-coalescing write buffer between the L1 data cache (write-through path) and the memory interface. Cache word writes are merged into line-sized entries held in a circular FIFO. Entries drain to memory one line per transaction, carrying a per-word valid mask. Reads are checked against the buffer so the cache never reads stale memory.

Parameters:
DEPTH, 16, number of line entries; power of two, >= 2
WORDS, 4, words per line; power of two, >= 2
ADDR_W, 32, word-address width
DATA_W, 32, word width
DRAIN_THRESH, 1, occupancy at or above which draining starts without flush; 1..DEPTH

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wr_valid  in  1  cache write request
wr_ready  out  1  write accepted this cycle when wr_valid && wr_ready
wr_addr  in  ADDR_W  word address; low log2(WORDS) bits = word index, upper bits = line tag
wr_data  in  DATA_W  write data
rd_check  in  1  cache read probe
rd_addr  in  ADDR_W  probe word address
rd_hit  out  1  probe matches buffered data (combinational)
rd_data  out  DATA_W  forwarded word (see Optional Feature)
flush  in  1  level; drain regardless of DRAIN_THRESH
mem_req_valid  out  1  line write request
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  line base address, word index bits zero
mem_req_data  out  WORDS*DATA_W  line data, word 0 in LSBs
mem_req_mask  out  WORDS  per-word valid mask
mem_done  in  1  single-cycle pulse: accepted write complete
count  out  log2(DEPTH)+1  occupied entries
empty  out  1  count == 0
full  out  1  count == DEPTH

Behaviour:
- Reset (async): all entry masks cleared, head = tail = 0, count 0, FSM IDLE. Outputs: wr_ready 1, rd_hit 0, rd_data 0, mem_req_valid 0, mem_req_addr/data/mask 0, empty 1, full 0. Reset during REQ/WAIT abandons the transaction; a late mem_done after reset is ignored.
- Entry = tag, WORDS data words, WORDS-bit mask. An entry is occupied iff its mask is non-zero. Head is "in flight" while FSM != IDLE.
- Write merge: if an occupied, non-in-flight entry has a matching tag, the write updates that word and sets its mask bit. Last write wins. Merge is legal even when full.
- Invariant: at most one non-in-flight entry per tag.
- Write allocate: with no mergeable entry and !full, the write goes to the tail entry (mask = one-hot word bit), tail wraps modulo DEPTH, count +1.
- wr_ready = mergeable_hit || !full, computed from registered state only. A retire in the same cycle does not free a slot for that cycle's write.
- A write whose tag matches only the in-flight head allocates a new entry; it must never modify the in-flight entry.
- Drain FSM:
  - IDLE -> REQ when count >= DRAIN_THRESH or (flush && !empty).
  - REQ: mem_req_valid = 1; addr/data/mask from head, held stable until mem_req_ready; REQ -> WAIT on handshake.
  - WAIT -> IDLE on mem_done: head mask cleared, head wraps, count -1.
  - mem_done outside WAIT is ignored.
  - Minimum latency IDLE -> retire = 2 cycles after mem_req_ready.
- Simultaneous allocate and retire: count unchanged, both pointers advance.
- Read probe is combinational, no state change. Searches all occupied entries including in-flight. When several match, the youngest (closest to tail) wins. rd_hit = 0 when !rd_check.

Optional Feature:
WB_FORWARD_EN:
- Defined: rd_hit requires a tag match and that word's mask bit set in the selected entry. rd_data = that word, else 0.
- Undefined: rd_hit = tag match in any occupied entry (conservative; the cache stalls until drained). rd_data tied to 0.

Test Plan:
1. Reset, write 0x100..0x103 data 0xA0..0xA3 with DRAIN_THRESH=2 -> one entry, count 1, then drain: mem_req_addr 0x100, mask 4'b1111, data {A3,A2,A1,A0}.
2. DRAIN_THRESH=DEPTH=16: write 16 distinct tags -> full 1. 17th new tag -> wr_ready 0. Write to an existing tag -> wr_ready 1, count stays 16.
3. Hold mem_req_ready 0 with head in flight (tag 0x40). Write 0x101 -> new tail entry. Probe 0x101 -> rd_data = new data (forward on), i.e. youngest wins.
4. Full buffer, mem_done and new-tag write in same cycle -> write stalled that cycle, accepted next, count 16 -> 15 -> 16.
5. Write mask 4'b0010 entry, probe word 0 of same line -> rd_hit 0 with WB_FORWARD_EN, rd_hit 1 without.
6. Assert rst while in WAIT, then pulse mem_done -> count 0, mem_req_valid 0, no pointer change.
